wb_stage: RTL and testbench

//  Writeback stage of the RV32 pipeline; drives the wb_val/wb_en/wb_reg port the register-read stage consumes.

---
 rtl/wb_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_wb_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ============================================================================
// wb_stage -- RV32 writeback stage
//
// Accepts one retiring instruction per cycle from the memory stage and
// produces the register-file write (wb_val / wb_en / wb_reg) consumed by the
// register-read stage. The result is the ALU value, the link address PC+4,
// or aligned and extended load data. A load parks the stage in WAIT_LD until
// the data memory answers. While it waits, in_ready is low and stall is high.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined   -> retire_cnt port and CNT_W-bit retire counter are present
//   undefined -> no counter; all other behaviour is identical
//
// Parameters
//   CNT_W  retire counter width (only with WB_RETIRE_CNT_EN)
//   XLEN   datapath width, 32 only
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   ins_wb_in     instruction: opcode [6:0], rd [11:7], funct3 [14:12]
//   alu_res       ALU result / load effective address
//   pc_in         PC of the instruction
//   in_valid      upstream data valid
//   in_ready      stage can accept (low only while a load is outstanding)
//   dmem_rdata    data memory read word (word aligned)
//   dmem_rvalid   read response valid, only looked at in WAIT_LD
//   wb_val        register write value
//   wb_en         register write enable, one-cycle pulse
//   wb_reg        register write index
//   stall         load outstanding
//   misalign      one-cycle pulse when a misaligned load is dropped
//   retire_cnt    retired instruction count (WB_RETIRE_CNT_EN only)
// ============================================================================
module wb_stage #(
`ifdef WB_RETIRE_CNT_EN
    parameter int unsigned CNT_W = 64,
`endif
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     ins_wb_in,
    input  logic [XLEN-1:0] alu_res,
    input  logic [XLEN-1:0] pc_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_rvalid,
    output logic [XLEN-1:0] wb_val,
    output logic            wb_en,
    output logic [4:0]      wb_reg,
    output logic            stall,
    output logic            misalign
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_LD = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    state_t          r_state;
    state_t          w_state_nx;

    logic [XLEN-1:0] r_wb_val;
    logic            r_wb_en;
    logic [4:0]      r_wb_reg;
    logic            r_misalign;

    // Load context latched on accept, used when the response arrives
    logic [4:0]      r_ld_rd;
    logic [2:0]      r_ld_f3;
    logic [1:0]      r_ld_off;

    logic            w_accept;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_f3;
    logic [1:0]      w_off;
    logic            w_is_alu;
    logic            w_is_link;
    logic            w_is_load;
    logic            w_ld_misalign;
    logic            w_ld_start;
    logic            w_ld_resp;
    logic [XLEN-1:0] w_ld_data;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            w_unused;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    assign w_opcode  = ins_wb_in[6:0];
    assign w_rd      = ins_wb_in[11:7];
    assign w_f3      = ins_wb_in[14:12];
    assign w_off     = alu_res[1:0];
    assign w_unused  = ^ins_wb_in[31:15];

    assign w_accept  = in_valid && in_ready;
    assign w_is_alu  = (w_opcode == OP_OP) || (w_opcode == OP_OPIMM) ||
                       (w_opcode == OP_LUI) || (w_opcode == OP_AUIPC);
    assign w_is_link = (w_opcode == OP_JAL) || (w_opcode == OP_JALR);
    assign w_is_load = (w_opcode == OP_LOAD);

    // funct3[1] set covers LW and the reserved encodings, which behave as LW;
    // funct3[1:0]==01 is LH/LHU.
    always_comb begin
        w_ld_misalign = 1'b0;
        if (w_f3[1]) begin
            w_ld_misalign = (w_off != 2'b00);
        end else if (w_f3[0]) begin
            w_ld_misalign = w_off[0];
        end
    end

    assign w_ld_start = w_accept && w_is_load && !w_ld_misalign;
    assign w_ld_resp  = (r_state == S_WAIT_LD) && dmem_rvalid;

    // ------------------------------------------------------------------
    // Load data alignment and extension from the latched context
    // ------------------------------------------------------------------
    assign w_byte = dmem_rdata[{r_ld_off, 3'b000} +: 8];
    assign w_half = r_ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_ld_data = dmem_rdata;
        if (!r_ld_f3[1]) begin
            if (r_ld_f3[0]) begin
                w_ld_data = {{16{~r_ld_f3[2] & w_half[15]}}, w_half};
            end else begin
                w_ld_data = {{24{~r_ld_f3[2] & w_byte[7]}}, w_byte};
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b1;
        stall      = 1'b0;
        case (r_state)
            S_IDLE, S_WRITE: begin
                // WRITE behaves as IDLE for acceptance; the load write itself
                // was registered on the response edge.
                w_state_nx = w_ld_start ? S_WAIT_LD : S_IDLE;
            end
            S_WAIT_LD: begin
                in_ready = 1'b0;
                stall    = 1'b1;
                if (dmem_rvalid) begin
                    w_state_nx = S_WRITE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Writeback registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_val   <= '0;
            r_wb_en    <= 1'b0;
            r_wb_reg   <= '0;
            r_misalign <= 1'b0;
            r_ld_rd    <= '0;
            r_ld_f3    <= '0;
            r_ld_off   <= '0;
        end else begin
            r_wb_en    <= 1'b0;
            r_misalign <= 1'b0;
            if (w_ld_resp) begin
                if (r_ld_rd != 5'd0) begin
                    r_wb_en  <= 1'b1;
                    r_wb_val <= w_ld_data;
                    r_wb_reg <= r_ld_rd;
                end
            end else if (w_accept) begin
                if (w_is_load) begin
                    if (w_ld_misalign) begin
                        r_misalign <= 1'b1;
                    end else begin
                        r_ld_rd  <= w_rd;
                        r_ld_f3  <= w_f3;
                        r_ld_off <= w_off;
                    end
                end else if ((w_is_alu || w_is_link) && (w_rd != 5'd0)) begin
                    r_wb_en  <= 1'b1;
                    r_wb_reg <= w_rd;
                    r_wb_val <= w_is_link ? (pc_in + 32'd4) : alu_res;
                end
            end
        end
    end

    assign wb_val   = r_wb_val;
    assign wb_en    = r_wb_en;
    assign wb_reg   = r_wb_reg;
    assign misalign = r_misalign;

`ifdef WB_RETIRE_CNT_EN
    // ------------------------------------------------------------------
    // Retire counter: a load retires in WRITE, and the same edge may also
    // accept a new non-load, so up to two events are counted at once.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_retire_cnt;
    logic [1:0]       w_retire_inc;

    always_comb begin
        w_retire_inc = 2'd0;
        if (w_accept && (!w_is_load || w_ld_misalign)) begin
            w_retire_inc = w_retire_inc + 2'd1;
        end
        if (r_state == S_WRITE) begin
            w_retire_inc = w_retire_inc + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else begin
            r_retire_cnt <= r_retire_cnt + {{(CNT_W-2){1'b0}}, w_retire_inc};
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ============================================================================
// tb_wb_stage -- scoreboard bench for wb_stage
//
// The driver issues instructions and, at accept, pushes the expected
// register write (or misalign pulse) into a queue. An independent monitor pops
// and compares whenever wb_en or misalign is seen. Expected values come from a
// reference model written directly from the ISA load/result rules.
// ============================================================================
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ins_wb_in;
    logic [31:0] alu_res;
    logic [31:0] pc_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic [31:0] wb_val;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic        stall;
    logic        misalign;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ins_wb_in   (ins_wb_in),
        .alu_res     (alu_res),
        .pc_in       (pc_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dmem_rdata  (dmem_rdata),
        .dmem_rvalid (dmem_rvalid),
        .wb_val      (wb_val),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .stall       (stall),
        .misalign    (misalign)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        bit          mis;
        bit          is_wait;
        logic [31:0] val;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    longint unsigned exp_retire = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] alu,
                                   input logic [31:0] pc, input logic [31:0] rdata);
        exp_t            e;
        int              op;
        int              rd;
        int              f3;
        int              o;
        int              nb;
        longint unsigned raw;
        longint unsigned mask;
        op = int'(ins[6:0]);
        rd = int'(ins[11:7]);
        f3 = int'(ins[14:12]);
        o  = int'(alu[1:0]);
        e.en = 0; e.mis = 0; e.is_wait = 0; e.val = '0; e.rd = ins[11:7];
        if (op == 'h33 || op == 'h13 || op == 'h37 || op == 'h17) begin
            e.en  = (rd != 0);
            e.val = alu;
        end else if (op == 'h6F || op == 'h67) begin
            e.en  = (rd != 0);
            e.val = 32'(64'(pc) + 64'd4);
        end else if (op == 'h03) begin
            if (f3 == 0 || f3 == 4)      nb = 1;
            else if (f3 == 1 || f3 == 5) nb = 2;
            else                         nb = 4;
            if ((o % nb) != 0) begin
                e.mis = 1;
            end else begin
                e.is_wait = 1;
                mask = (64'd1 << (8 * nb)) - 64'd1;
                raw  = (64'(rdata) >> (8 * o)) & mask;
                if (nb < 4 && f3 < 4 && raw[8 * nb - 1]) raw = raw | ~mask;
                e.val = raw[31:0];
                e.en  = (rd != 0);
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3);
        logic [16:0] hi;
        hi = 17'($urandom);
        return {hi, f3, rd, op};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (wb_en === 1'b1 || misalign === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: wb_en=%0b misalign=%0b wb_reg=%0d wb_val=0x%0h, none expected",
                         wb_en, misalign, wb_reg, wb_val);
            end else begin
                e = exp_q.pop_front();
                if (wb_en !== e.en || misalign !== e.mis ||
                    (e.en && (wb_val !== e.val || wb_reg !== e.rd))) begin
                    errors++;
                    $display("FAIL wb_out: got en=%0b mis=%0b reg=%0d val=0x%08h expected en=%0b mis=%0b reg=%0d val=0x%08h",
                             wb_en, misalign, wb_reg, wb_val, e.en, e.mis, e.rd, e.val);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic spur();
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
    endtask

    task automatic idle(input int n);
        in_valid    = 1'b0;
        dmem_rvalid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] rdata, input int dly, input bit gap);
        exp_t e;
        int   g;
        int   stalls;
        e = model(ins, alu, pc, rdata);
        if (gap) begin
            in_valid = 1'b0;
            spur();
            @(posedge clk); #1;
        end
        g = 0;
        while (in_ready !== 1'b1 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", 64'(in_ready), 64'd1);
        end
        ins_wb_in = ins;
        alu_res   = alu;
        pc_in     = pc;
        in_valid  = 1'b1;
        spur();
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (e.en || e.mis) exp_q.push_back(e);
        if (e.is_wait) begin
            stalls = 0;
            for (int c = 1; c <= dly; c++) begin
                if (stall === 1'b1 && in_ready === 1'b0) stalls++;
                dmem_rvalid = (c == dly);
                dmem_rdata  = (c == dly) ? rdata : $urandom;
                @(posedge clk); #1;
            end
            dmem_rvalid = 1'b0;
            chk("load_stall_cycles", 64'(stalls), 64'(dly));
        end else begin
            chk("no_stall_after_accept", {62'd0, stall, in_ready}, 64'd1);
        end
        exp_retire++;
    endtask

    logic [6:0] ops [10];

    initial begin
        logic [6:0]  op;
        logic [4:0]  rd;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h03};
        rst = 1'b1; in_valid = 1'b0; ins_wb_in = '0; alu_res = '0; pc_in = '0;
        dmem_rdata = '0; dmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_wb_val", 64'(wb_val), 64'd0);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_wb_reg", 64'(wb_reg), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_retire_cnt", retire_cnt, 64'd0);
`endif

        // Directed cases
        send(mk(7'h33, 5'd5, 3'd0), 32'h0000_1234, 32'h100, 32'h0, 1, 0);
        send(mk(7'h6F, 5'd1, 3'd0), 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 0);
        send(mk(7'h03, 5'd7, 3'd0), 32'h0000_2003, 32'h0, 32'h80AA_BBCC, 4, 0);
        send(mk(7'h03, 5'd8, 3'd5), 32'h0000_2002, 32'h0, 32'h80AA_BBCC, 2, 0);
        send(mk(7'h03, 5'd9, 3'd2), 32'h0000_2002, 32'h0, 32'h0, 1, 0);
        send(mk(7'h13, 5'd0, 3'd0), 32'hDEAD_BEEF, 32'h0, 32'h0, 1, 0);
        idle(3);
        chk("hold_wb_val", 64'(wb_val), 64'h80AA);
        chk("hold_wb_reg", 64'(wb_reg), 64'd8);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            send(mk(op, rd, 3'($urandom)), $urandom, $urandom, $urandom,
                 $urandom_range(1, 5), ($urandom_range(0, 3) == 0));
        end
        idle(4);
        chk("queue_drained_random", 64'(exp_q.size()), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt_random", retire_cnt, exp_retire);
`endif

        // Reset while a load is outstanding, then a late response
        send(mk(7'h13, 5'd3, 3'd0), 32'h55, 32'h0, 32'h0, 1, 0);
        ins_wb_in = mk(7'h03, 5'd4, 3'd2); alu_res = 32'h40; in_valid = 1'b1;
        dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ld_wait_stall", 64'(stall), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_retire = 0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("midrst_wb_en", 64'(wb_en), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_wb_val", 64'(wb_val), 64'd0);
        chk("midrst_wb_reg", 64'(wb_reg), 64'd0);
        chk("midrst_in_ready2", 64'(in_ready), 64'd1);
        chk("queue_after_rst", 64'(exp_q.size()), 64'd0);

        // Ten mixed instructions: 3 loads, 1 store, 1 misaligned
        send(mk(7'h03, 5'd10, 3'd0), 32'h1, 32'h0, $urandom, 3, 0);
        send(mk(7'h33, 5'd11, 3'd0), $urandom, 32'h0, 32'h0, 1, 0);
        send(mk(7'h23, 5'd12, 3'd2), $urandom, 32'h0, 32'h0, 1, 0);
        send(mk(7'h03, 5'd13, 3'd2), 32'h100, 32'h0, $urandom, 1, 0);
        send(mk(7'h03, 5'd14, 3'd1), 32'h101, 32'h0, 32'h0, 1, 0);
        send(mk(7'h67, 5'd15, 3'd0), 32'h0, $urandom, 32'h0, 1, 0);
        send(mk(7'h03, 5'd16, 3'd5), 32'h102, 32'h0, $urandom, 2, 0);
        send(mk(7'h13, 5'd17, 3'd0), $urandom, 32'h0, 32'h0, 1, 0);
        send(mk(7'h63, 5'd18, 3'd0), $urandom, 32'h0, 32'h0, 1, 0);
        send(mk(7'h37, 5'd19, 3'd0), $urandom, 32'h0, 32'h0, 1, 0);
        idle(4);
        chk("queue_drained_final", 64'(exp_q.size()), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt_ten", retire_cnt, 64'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
